// File: rtl/xbar7_sw_alloc.sv
// Switch allocator for the 7-port router crossbar: per-output round-robin arbiters
// with optional head-to-tail wormhole locking (enabled by defining SA_WORMHOLE_EN).

module xbar7_sw_alloc_arb #(
    parameter int NP = 7,
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NP-1:0] cand,
    input  logic [NP-1:0] tail,
    input  logic          rdy,
    output logic [NP-1:0] gnt,
    output logic          lock,
    output logic [TW-1:0] owner
);
    logic [TW-1:0] ptr_q;
    logic [TW-1:0] win;
    logic [TW-1:0] win_nxt;
    logic [TW-1:0] idx;
    logic [TW:0]   sum;
    logic          hit;

    always_comb begin
        gnt = '0;
        win = '0;
        hit = 1'b0;
        idx = '0;
        sum = '0;
        if (rdy) begin
            if (lock) begin
                // a locked output serves only its owner; everyone else waits
                if (cand[owner]) begin
                    gnt[owner] = 1'b1;
                    win        = owner;
                    hit        = 1'b1;
                end
            end else begin
                for (int k = 0; k < NP; k++) begin
                    sum = {1'b0, ptr_q} + (TW+1)'(k);
                    if (sum >= (TW+1)'(NP))
                        sum = sum - (TW+1)'(NP);
                    idx = sum[TW-1:0];
                    if (!hit && cand[idx]) begin
                        gnt[idx] = 1'b1;
                        win      = idx;
                        hit      = 1'b1;
                    end
                end
            end
        end
    end

    assign win_nxt = (win == TW'(NP-1)) ? '0 : win + 1'b1;

`ifdef SA_WORMHOLE_EN
    logic          lock_q;
    logic [TW-1:0] owner_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            lock_q  <= 1'b0;
            owner_q <= '0;
        end else if (hit) begin
            if (tail[win]) begin
                lock_q <= 1'b0;
                ptr_q  <= win_nxt;
            end else if (!lock_q) begin
                lock_q  <= 1'b1;
                owner_q <= win;
            end
        end
    end

    assign lock  = lock_q;
    assign owner = owner_q;
`else
    logic unused_tail;
    assign unused_tail = ^tail;

    // every flit is its own packet: pointer moves on each grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr_q <= '0;
        else if (hit)
            ptr_q <= win_nxt;
    end

    assign lock  = 1'b0;
    assign owner = '0;
`endif
endmodule

module xbar7_sw_alloc #(
    parameter int NP = 7,
    parameter int TW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NP-1:0]    req_vld,
    input  logic [NP*TW-1:0] req_targ,
    input  logic [NP-1:0]    req_tail,
    input  logic [NP-1:0]    out_rdy,
    input  logic             err_clr,
    output logic [NP-1:0]    cb_ctrl,
    output logic [NP-1:0]    lock,
    output logic [1:0]       err
);
    logic [NP-1:0][TW-1:0] targ;
    logic [NP-1:0][TW-1:0] owner;
    logic [NP-1:0][NP-1:0] cand;   // [output][input]
    logic [NP-1:0][NP-1:0] gnt;    // [output][input]
    logic [NP-1:0]         owns_other;
    logic [1:0]            err_set;
    logic [1:0]            err_q;

    assign targ = req_targ;

    // an input holding a lock elsewhere must not compete for any other output
    always_comb begin
        owns_other = '0;
        for (int i = 0; i < NP; i++)
            for (int j = 0; j < NP; j++)
                if (lock[j] && owner[j] == TW'(i) && targ[i] != TW'(j+1))
                    owns_other[i] = 1'b1;
    end

    always_comb begin
        cand = '0;
        for (int j = 0; j < NP; j++)
            for (int i = 0; i < NP; i++)
                cand[j][i] = req_vld[i] && targ[i] == TW'(j+1) && !owns_other[i];
    end

    for (genvar j = 0; j < NP; j++) begin : g_out
        xbar7_sw_alloc_arb #(.NP(NP), .TW(TW)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .cand  (cand[j]),
            .tail  (req_tail),
            .rdy   (out_rdy[j]),
            .gnt   (gnt[j]),
            .lock  (lock[j]),
            .owner (owner[j])
        );
    end

    always_comb begin
        cb_ctrl = '0;
        for (int j = 0; j < NP; j++)
            cb_ctrl = cb_ctrl | gnt[j];
    end

    always_comb begin
        err_set = '0;
        for (int i = 0; i < NP; i++) begin
            if (req_vld[i] && targ[i] == '0)
                err_set[0] = 1'b1;
`ifdef SA_WORMHOLE_EN
            if (req_vld[i] && owns_other[i])
                err_set[1] = 1'b1;
`endif
        end
    end

    // a new error in the clear cycle survives the clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            err_q <= '0;
        else
            err_q <= (err_clr ? 2'b00 : err_q) | err_set;
    end

    assign err = err_q;
endmodule
